// File: rtl/collector_pkg.sv
// Shared types and constants for the serial bit collector.
package collector_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_shift_reg.sv
// Serial-in shift register with bit counter; flags the completing bit.
module bit_shift_reg
    import collector_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_i,
    input  logic             vld_i,
    input  logic             clear_i,
    output logic             done_o,
    output logic [WIDTH-1:0] word_o,
    output logic [CW-1:0]    cnt_o
);

    logic [WIDTH-1:0] sr_q, sr_d, shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             take;

    always_comb begin
        take    = vld_i && !clear_i;
        shifted = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], bit_i}
                                   : {bit_i, sr_q[WIDTH-1:1]};
        done_o  = take && (cnt_q == CW'(WIDTH - 1));
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        if (clear_i || done_o) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (take) begin
            sr_d  = shifted;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // Completed word includes the bit being accepted on this edge.
    assign word_o = shifted;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/bit_collector.sv
// Assembles serial bits into words behind a one-deep valid/ready holding register.
module bit_collector
    import collector_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_vld,
    input  logic             clear,
    output logic [WIDTH-1:0] word_out,
    output logic             word_vld,
    input  logic             word_rdy,
    output logic [CW-1:0]    bit_cnt,
    output logic             overflow
);

    out_state_e       state_q;
    logic [WIDTH-1:0] word_q;
    logic             vld_q;
    logic             ovf_q;
    logic             done;
    logic [WIDTH-1:0] next_word;

    bit_shift_reg #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_sr (
        .clk    (clk),
        .rst_n  (rst_n),
        .bit_i  (bit_in),
        .vld_i  (bit_vld),
        .clear_i(clear),
        .done_o (done),
        .word_o (next_word),
        .cnt_o  (bit_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            word_q  <= '0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (done) begin
                        word_q  <= next_word;
                        vld_q   <= 1'b1;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (word_rdy) begin
                        if (done) begin
                            word_q <= next_word;
                        end else begin
                            vld_q   <= 1'b0;
                            state_q <= EMPTY;
                        end
                    end else if (done) begin
                        ovf_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    vld_q   <= 1'b0;
                end
            endcase
            // A completing word cannot coincide with clear, so this never races the set.
            if (clear) ovf_q <= 1'b0;
        end
    end

    assign word_out = word_q;
    assign word_vld = vld_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bit_collector.sv
// Scoreboard bench for bit_collector, MSB-first and LSB-first instances side by side.
module tb_bit_collector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_vld = 1'b0;
    logic       clear = 1'b0;
    logic       word_rdy = 1'b0;
    logic [7:0] wm, wl;
    logic       vm, vl, om, ol;
    logic [3:0] cm, cl;

    int errors = 0;
    int checks = 0;
    logic [7:0] q_m[$];
    logic [7:0] q_l[$];
    logic [7:0] em, el;

    always #5 clk = ~clk;

    bit_collector #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld),
        .clear(clear), .word_out(wm), .word_vld(vm), .word_rdy(word_rdy),
        .bit_cnt(cm), .overflow(om)
    );

    bit_collector #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld),
        .clear(clear), .word_out(wl), .word_vld(vl), .word_rdy(word_rdy),
        .bit_cnt(cl), .overflow(ol)
    );

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit_vld = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drives w[7] first; the last edge uses rdy_last, optional idle gaps between bits.
    task automatic send_bits(input logic [7:0] w, input int nb,
                             input logic rdy, input logic rdy_last,
                             input int gap);
        for (int i = 0; i < nb; i++) begin
            bit_in   = w[7-i];
            bit_vld  = 1'b1;
            word_rdy = (i == nb - 1) ? rdy_last : rdy;
            tick();
            if (gap > 0 && i != nb - 1) begin
                bit_vld = 1'b0;
                word_rdy = rdy;
                for (int g = 0; g < gap; g++) tick();
            end
        end
        bit_vld = 1'b0;
    endtask

    task automatic push(input logic [7:0] w);
        q_m.push_back(w);
        q_l.push_back(rev8(w));
    endtask

    task automatic pop_check(input string name);
        em = q_m.pop_front();
        el = q_l.pop_front();
        checks++;
        if (wm !== em || vm !== 1'b1) begin
            errors++;
            $display("FAIL %s msb: word=%h vld=%b expected word=%h vld=1", name, wm, vm, em);
        end
        checks++;
        if (wl !== el || vl !== 1'b1) begin
            errors++;
            $display("FAIL %s lsb: word=%h vld=%b expected word=%h vld=1", name, wl, vl, el);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({wm, vm, cm, om} !== 14'd0 || {wl, vl, cl, ol} !== 14'd0) begin
            errors++;
            $display("FAIL reset: msb=%h/%b/%0d/%b lsb=%h/%b/%0d/%b expected all 0",
                     wm, vm, cm, om, wl, vl, cl, ol);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_msb_lsb();
        send_bits(8'hB2, 7, 1'b1, 1'b1, 0);
        checks++;
        if (cm !== 4'd7 || vm !== 1'b0) begin
            errors++;
            $display("FAIL cnt7: cnt=%0d vld=%b expected cnt=7 vld=0", cm, vm);
        end
        bit_in = 1'b0; bit_vld = 1'b1; tick(); bit_vld = 1'b0;
        push(8'hB2);
        pop_check("b2_word");
        checks++;
        if (cm !== 4'd0) begin
            errors++;
            $display("FAIL cnt_wrap: cnt=%0d expected 0", cm);
        end
        tick();
        checks++;
        if (vm !== 1'b0 || vl !== 1'b0) begin
            errors++;
            $display("FAIL one_cycle_vld: vld=%b/%b expected 0/0", vm, vl);
        end
    endtask

    task automatic test_gaps();
        send_bits(8'h6E, 8, 1'b0, 1'b0, 2);
        push(8'h6E);
        pop_check("gap_word");
        word_rdy = 1'b1;
        tick();
        word_rdy = 1'b0;
    endtask

    task automatic test_overflow();
        send_bits(8'hB2, 8, 1'b0, 1'b0, 0);
        push(8'hB2);
        send_bits(8'hFF, 8, 1'b0, 1'b0, 0);
        tick();
        checks++;
        if (om !== 1'b1 || ol !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b/%b expected 1/1", om, ol);
        end
        pop_check("ovf_hold");
        clear = 1'b1; tick(); clear = 1'b0;
        checks++;
        if (om !== 1'b0 || vm !== 1'b1 || wm !== 8'hB2) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b vld=%b word=%h expected 0 1 b2", om, vm, wm);
        end
        word_rdy = 1'b1; tick(); word_rdy = 1'b0;
        checks++;
        if (vm !== 1'b0) begin
            errors++;
            $display("FAIL drain: vld=%b expected 0", vm);
        end
    endtask

    task automatic test_back_to_back();
        send_bits(8'h33, 8, 1'b0, 1'b0, 0);
        send_bits(8'h0F, 8, 1'b0, 1'b1, 0);
        word_rdy = 1'b0;
        push(8'h0F);
        pop_check("load_word");
        checks++;
        if (om !== 1'b0 || ol !== 1'b0) begin
            errors++;
            $display("FAIL load_ovf: ovf=%b/%b expected 0/0", om, ol);
        end
        word_rdy = 1'b1; tick(); word_rdy = 1'b0;
    endtask

    task automatic test_reset_mid();
        send_bits(8'hFF, 5, 1'b0, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cm !== 4'd0 || vm !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: cnt=%0d vld=%b expected 0 0", cm, vm);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_bits(8'hA5, 8, 1'b0, 1'b0, 0);
        push(8'hA5);
        pop_check("after_reset");
        word_rdy = 1'b1; tick(); word_rdy = 1'b0;
    endtask

    task automatic test_clear_same();
        send_bits(8'hE0, 3, 1'b0, 1'b0, 0);
        bit_in = 1'b1; bit_vld = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0; bit_vld = 1'b0;
        checks++;
        if (cm !== 4'd0 || cl !== 4'd0) begin
            errors++;
            $display("FAIL clear_cnt: cnt=%0d/%0d expected 0/0", cm, cl);
        end
        send_bits(8'h3C, 7, 1'b0, 1'b0, 0);
        checks++;
        if (vm !== 1'b0 || cm !== 4'd7) begin
            errors++;
            $display("FAIL clear_discard: vld=%b cnt=%0d expected 0 7", vm, cm);
        end
        bit_in = 1'b0; bit_vld = 1'b1; tick(); bit_vld = 1'b0;
        push(8'h3C);
        pop_check("clear_word");
    endtask

    initial begin
        test_reset();
        test_msb_lsb();
        test_gaps();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_clear_same();
        checks++;
        if (q_m.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d left, expected 0", q_m.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
